// File: rtl/m_stage_mem_port_pkg.sv
`default_nettype none
// ============================================================================
// m_stage_mem_port_pkg : DMOp size/sign codes, M-stage FSM states, alignment helper
// Rev 1.0
// ============================================================================
package m_stage_mem_port_pkg;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  function automatic logic mem_misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic res;
    res = 1'b0;
    case (op)
      DM_W:        res = (lo != 2'b00);
      DM_H, DM_HU: res = lo[0];
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_stage_mem_port_if.sv
`default_nettype none
// ============================================================================
// m_stage_mem_port_if : req/gnt/rvalid data-memory bus between M stage and memory
// Rev 1.0
// ============================================================================
interface m_stage_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/m_mem_lane.sv
`default_nettype none
// ============================================================================
// m_mem_lane : little-endian byte-enable/store-data lane shift and load extension
// Rev 1.0
// ============================================================================
module m_mem_lane
  import m_stage_mem_port_pkg::*;
(
  input  logic [2:0]  dmop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (dmop_i)
      DM_B, DM_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      DM_H, DM_HU: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
    case (dmop_i)
      DM_B:    load_data_o = {{24{w_byte[7]}}, w_byte};
      DM_BU:   load_data_o = {24'd0, w_byte};
      DM_H:    load_data_o = {{16{w_half[15]}}, w_half};
      DM_HU:   load_data_o = {16'd0, w_half};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/m_stage_mem_port.sv
`default_nettype none
// ============================================================================
// m_stage_mem_port : M pipeline stage driving a variable-latency req/gnt/rvalid data memory
// Rev 1.0
// ============================================================================
module m_stage_mem_port
  import m_stage_mem_port_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              En,
  input  logic [31:0]       IR_in,
  input  logic [31:0]       PC_in,
  input  logic [ADDR_W-1:0] Y_in,
  input  logic [31:0]       V2_in,
  input  logic              MemRd_in,
  input  logic              MemWr_in,
  input  logic [2:0]        DMOp_in,
  input  logic [4:0]        W_RFA3_in,
  input  logic [31:0]       W_RFWD_in,
  input  logic              W_RFWr_in,
  input  logic              W_Fwd_Ready_in,
  m_stage_mem_port_if.master mem,
  output logic [31:0]       IR_out,
  output logic [31:0]       PC_out,
  output logic [ADDR_W-1:0] Y_out,
  output logic [31:0]       RD_out,
  output logic              M_Stall,
  output logic              M_AdEL,
  output logic              M_AdES,
  output logic              M_BusErr
);

  state_t            state_q;
  logic [31:0]       ir_q, pc_q, v2_q, rd_q, wdata_q;
  logic [ADDR_W-1:0] y_q;
  logic              memrd_q, memwr_q, first_q;
  logic [2:0]        dmop_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adel_q, ades_q, buserr_q;

  logic        w_load, w_misal, w_memop, w_tmo;
  logic [31:0] w_fwd_rt, w_store_data, w_load_data;

  assign M_Stall = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign w_load  = En && !Flush && !M_Stall;
  assign w_misal = mem_misaligned(DMOp_in, Y_in[1:0]);
  assign w_memop = MemRd_in || MemWr_in;
  assign cnt_d   = cnt_q + 1'b1;
  assign w_tmo   = (cnt_q >= CNT_W'(TIMEOUT - 1));

  // W-stage forward is only valid in the first resident cycle; afterwards the snapshot is replayed.
  assign w_fwd_rt = (ir_q[20:16] == 5'd0) ? 32'd0 :
                    ((ir_q[20:16] == W_RFA3_in) && W_RFWr_in && W_Fwd_Ready_in) ? W_RFWD_in : v2_q;
  assign w_store_data = first_q ? w_fwd_rt : wdata_q;

  m_mem_lane u_lane (
    .dmop_i       (dmop_q),
    .addr_lo_i    (y_q[1:0]),
    .store_data_i (w_store_data),
    .rdata_i      (mem.mem_rdata),
    .be_o         (mem.mem_be),
    .wdata_o      (mem.mem_wdata),
    .load_data_o  (w_load_data)
  );

  assign mem.mem_req  = (state_q == ST_ISSUE);
  assign mem.mem_we   = memwr_q;
  assign mem.mem_addr = {y_q[ADDR_W-1:2], 2'b00};

  assign IR_out   = ir_q;
  assign PC_out   = pc_q;
  assign Y_out    = y_q;
  assign RD_out   = rd_q;
  assign M_AdEL   = adel_q;
  assign M_AdES   = ades_q;
  assign M_BusErr = buserr_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;  pc_q    <= '0;  y_q    <= '0;  v2_q  <= '0;
      memrd_q  <= 1'b0; memwr_q <= 1'b0; dmop_q <= '0;
      rd_q     <= '0;  wdata_q <= '0;  cnt_q  <= '0;  first_q <= 1'b0;
      adel_q   <= 1'b0; ades_q <= 1'b0; buserr_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (first_q) wdata_q <= w_fwd_rt;
      if (Flush) begin
        ir_q    <= '0;  pc_q    <= '0;  y_q    <= '0;  v2_q <= '0;
        memrd_q <= 1'b0; memwr_q <= 1'b0; dmop_q <= '0;
        rd_q    <= '0;  adel_q  <= 1'b0; ades_q <= 1'b0; buserr_q <= 1'b0;
        cnt_q   <= cnt_d;
        // Once granted, the response must still be absorbed before the bus is free again.
        case (state_q)
          ST_ISSUE: state_q <= (mem.mem_gnt && !mem.mem_rvalid) ? ST_DRAIN : ST_IDLE;
          ST_WAIT:  state_q <= mem.mem_rvalid ? ST_IDLE : ST_DRAIN;
          ST_DRAIN: state_q <= (mem.mem_rvalid || w_tmo) ? ST_IDLE : ST_DRAIN;
          default:  state_q <= ST_IDLE;
        endcase
      end else if (w_load) begin
        ir_q    <= IR_in;   pc_q    <= PC_in;    y_q    <= Y_in;  v2_q <= V2_in;
        memrd_q <= MemRd_in; memwr_q <= MemWr_in; dmop_q <= DMOp_in;
        rd_q    <= '0;  cnt_q <= '0;  first_q <= 1'b1;
        adel_q  <= MemRd_in && w_misal;
        ades_q  <= MemWr_in && w_misal;
        buserr_q <= 1'b0;
        state_q <= (w_memop && !w_misal) ? ST_ISSUE : ST_IDLE;
      end else begin
        case (state_q)
          ST_ISSUE: begin
            cnt_q <= cnt_d;
            if (mem.mem_gnt && mem.mem_rvalid) begin
              state_q <= ST_DONE;
              if (memrd_q) rd_q <= w_load_data;
            end else if (w_tmo) begin
              state_q  <= ST_ERR;
              buserr_q <= 1'b1;
            end else if (mem.mem_gnt) begin
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            cnt_q <= cnt_d;
            if (mem.mem_rvalid) begin
              state_q <= ST_DONE;
              if (memrd_q) rd_q <= w_load_data;
            end else if (w_tmo) begin
              state_q  <= ST_ERR;
              buserr_q <= 1'b1;
            end
          end
          ST_DRAIN: begin
            cnt_q <= cnt_d;
            if (mem.mem_rvalid || w_tmo) state_q <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
